// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard/sequencing control: load-use and branch-operand stalls, branch/jump flush, halt drain.
// Latency: enables, flush and bubble are combinational in the same cycle; halted is registered (first HALT cycle).
// Backpressure: a hazard holds PC/IF-ID and bubbles ID-EX; DRAIN and HALT hold the front end indefinitely.
module id_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_uses_src2,
    input  logic              id_branch,
    input  logic              id_jump,
    input  logic              pc_source,
    input  logic              id_clock_off,
    input  logic              ex_reg_write,
    input  logic              ex_mem_r,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              mem_mem_r,
    input  logic [REG_AW-1:0] mem_dest,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t          state;
    logic [DW-1:0]   drain_cnt;
    logic            m1_ex;
    logic            m1_mem;
    logic            lu;
    logic            bx;
    logic            bm;
    logic            stall;
    logic            redirect;
    logic            halt_req;
    logic            stall_inc;
    logic            flush_inc;

    // x0 is hardwired to zero, so a zero destination never creates a dependency.
    function automatic logic m1(input logic [REG_AW-1:0] dest,
                                input logic [REG_AW-1:0] src1,
                                input logic [REG_AW-1:0] src2,
                                input logic              uses_src2);
        return (dest != '0) && ((dest == src1) || (uses_src2 && (dest == src2)));
    endfunction

    assign m1_ex    = m1(ex_dest, id_src1, id_src2, id_uses_src2);
    assign m1_mem   = m1(mem_dest, id_src1, id_src2, id_uses_src2);
    assign lu       = ex_mem_r & m1_ex;
    assign bx       = id_branch & ex_reg_write & m1_ex;
    assign bm       = id_branch & mem_mem_r & m1_mem;
    assign stall    = lu | bx | bm;
    assign redirect = (id_branch & pc_source) | id_jump;

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b1;
        halt_req    = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (reset_n && (state == RUN)) begin
            if (stall) begin
                stall_inc = 1'b1;
            end else if (id_clock_off) begin
                // The halt instruction itself moves on; everything behind it is squashed.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b0;
                halt_req    = 1'b1;
            end else if (redirect) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b0;
                flush_inc   = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_bubble = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                    if (drain_cnt == DRAIN_LAST) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: hazards, x0 guard, flush priority, halt drain, counter saturation.
module tb_id_hazard_ctrl;

    logic        clock;
    logic        reset_n;
    logic [4:0]  id_src1;
    logic [4:0]  id_src2;
    logic        id_uses_src2;
    logic        id_branch;
    logic        id_jump;
    logic        pc_source;
    logic        id_clock_off;
    logic        ex_reg_write;
    logic        ex_mem_r;
    logic [4:0]  ex_dest;
    logic        mem_mem_r;
    logic [4:0]  mem_dest;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checks   = 0;
    int failures = 0;

    id_hazard_ctrl #(.REG_AW(5), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_uses_src2 (id_uses_src2),
        .id_branch    (id_branch),
        .id_jump      (id_jump),
        .pc_source    (pc_source),
        .id_clock_off (id_clock_off),
        .ex_reg_write (ex_reg_write),
        .ex_mem_r     (ex_mem_r),
        .ex_dest      (ex_dest),
        .mem_mem_r    (mem_mem_r),
        .mem_dest     (mem_dest),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the four front-end controls together.
    task automatic chk_ctl(input string tag, input logic pw, input logic iw,
                           input logic fl, input logic bb);
        chk1({tag, ".pc_write"},    pc_write,    pw);
        chk1({tag, ".ifid_write"},  ifid_write,  iw);
        chk1({tag, ".ifid_flush"},  ifid_flush,  fl);
        chk1({tag, ".idex_bubble"}, idex_bubble, bb);
    endtask

    task automatic clr();
        id_src1 = 5'd0; id_src2 = 5'd0; id_uses_src2 = 1'b0;
        id_branch = 1'b0; id_jump = 1'b0; pc_source = 1'b0; id_clock_off = 1'b0;
        ex_reg_write = 1'b0; ex_mem_r = 1'b0; ex_dest = 5'd0;
        mem_mem_r = 1'b0; mem_dest = 5'd0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clr();
        reset_n = 1'b0;
        id_src1 = 5'd1; // a plain ALU op in ID: must still be held off by reset
        #1;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        chk1("reset.halted", halted, 1'b0);
        chk16("reset.stall_cnt", stall_cnt, 16'd0);
        chk16("reset.flush_cnt", flush_cnt, 16'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        chk_ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // Load-use on rs
        clr(); ex_mem_r = 1'b1; ex_dest = 5'd5; id_src1 = 5'd5;
        #1 chk_ctl("lu", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk16("lu.stall_cnt", stall_cnt, 16'd1);
        clr(); ex_dest = 5'd5; id_src1 = 5'd5; // EX no longer a load
        #1 chk_ctl("lu.after", 1'b1, 1'b1, 1'b0, 0);
        tick();
        chk16("lu.after.stall_cnt", stall_cnt, 16'd1);

        // rt only matters when the ID instruction reads it
        clr(); ex_mem_r = 1'b1; ex_dest = 5'd9; id_src2 = 5'd9;
        #1 chk1("rt.unused.pc_write", pc_write, 1'b1);
        id_uses_src2 = 1'b1;
        #1 chk1("rt.used.pc_write", pc_write, 1'b0);
        tick();
        chk16("rt.stall_cnt", stall_cnt, 16'd2);

        // x0 never matches
        clr(); ex_mem_r = 1'b1; ex_dest = 5'd0; id_src1 = 5'd0;
        #1 chk_ctl("x0", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk16("x0.stall_cnt", stall_cnt, 16'd2);

        // Branch on an ALU result in EX stalls; a non-branch does not
        clr(); ex_reg_write = 1'b1; ex_dest = 5'd4; id_src1 = 5'd4;
        #1 chk1("bx.nobranch.pc_write", pc_write, 1'b1);
        id_branch = 1'b1;
        #1 chk1("bx.branch.pc_write", pc_write, 1'b0);
        tick();
        chk16("bx.stall_cnt", stall_cnt, 16'd3);

        // Branch on a load: bx then bm, then resolve taken
        clr(); id_branch = 1'b1; id_src1 = 5'd3; id_src2 = 5'd7; id_uses_src2 = 1'b1;
        ex_mem_r = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd7;
        #1 chk_ctl("bload.c1", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        ex_mem_r = 1'b0; ex_reg_write = 1'b0; ex_dest = 5'd0;
        mem_mem_r = 1'b1; mem_dest = 5'd7;
        #1 chk_ctl("bload.c2", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        mem_mem_r = 1'b0; mem_dest = 5'd0; pc_source = 1'b1;
        #1 chk_ctl("bload.c3", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk16("bload.stall_cnt", stall_cnt, 16'd5);
        chk16("bload.flush_cnt", flush_cnt, 16'd1);

        // Jump while stalled: flush waits for the hazard to clear
        clr(); id_jump = 1'b1; ex_mem_r = 1'b1; ex_dest = 5'd5; id_src1 = 5'd5;
        #1 chk_ctl("jstall.c1", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        ex_mem_r = 1'b0;
        #1 chk_ctl("jstall.c2", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk16("jstall.stall_cnt", stall_cnt, 16'd6);
        chk16("jstall.flush_cnt", flush_cnt, 16'd2);

        // Stall beats halt: no drain starts
        clr(); id_clock_off = 1'b1; ex_mem_r = 1'b1; ex_dest = 5'd6; id_src1 = 5'd6;
        #1 chk_ctl("hstall", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        clr();
        #1 chk_ctl("hstall.after", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk16("hstall.stall_cnt", stall_cnt, 16'd7);

        // Halt beats jump, then three drain cycles, then HALT
        clr(); id_clock_off = 1'b1; id_jump = 1'b1;
        #1 chk_ctl("halt.c0", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk16("halt.flush_cnt", flush_cnt, 16'd2);
        for (int i = 0; i < 3; i++) begin
            clr(); id_jump = 1'(i); id_branch = 1'b1; pc_source = 1'b1;
            ex_mem_r = 1'b1; ex_dest = 5'd2; id_src1 = 5'd2;
            #1 chk_ctl($sformatf("drain%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
            chk1($sformatf("drain%0d.halted", i), halted, 1'b0);
            tick();
        end
        chk1("halt.halted", halted, 1'b1);
        chk16("halt.stall_cnt", stall_cnt, 16'd7);
        for (int i = 0; i < 3; i++) begin
            clr(); id_branch = 1'(i); pc_source = 1'b1; id_jump = 1'(~i);
            #1 chk_ctl($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            chk1($sformatf("hold%0d.halted", i), halted, 1'b1);
        end
        chk16("hold.flush_cnt", flush_cnt, 16'd2);

        // Asynchronous reset out of HALT
        clr();
        #2 reset_n = 1'b0;
        #1;
        chk1("rst.halted", halted, 1'b0);
        chk1("rst.pc_write", pc_write, 1'b0);
        chk16("rst.stall_cnt", stall_cnt, 16'd0);
        chk16("rst.flush_cnt", flush_cnt, 16'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        #1 chk_ctl("rst.run", 1'b1, 1'b1, 1'b0, 1'b0);

        // Saturation of stall_cnt
        clr(); ex_mem_r = 1'b1; ex_dest = 5'd8; id_src1 = 5'd8;
        tick();
        chk16("sat.first", stall_cnt, 16'd1);
        repeat (65534) @(posedge clock);
        #1 chk16("sat.max", stall_cnt, 16'hFFFF);
        repeat (4) @(posedge clock);
        #1 chk16("sat.hold", stall_cnt, 16'hFFFF);
        chk16("sat.flush_cnt", flush_cnt, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Hazard and sequencing controller for the instruction-decode stage of the 5-stage MIPS pipeline.
- Stalls PC/IF-ID and inserts ID-EX bubbles on load-use and branch-operand hazards.
- Flushes IF-ID on taken branches and jumps resolved in ID.
- On the decode stage's clock_off (halt) indication, drains the pipeline and parks in HALT; keeps saturating stall and flush event counters.

Parameters:
REG_AW, 5, register address width
DRAIN_CYCLES, 3, cycles spent in DRAIN before HALT (EX, MEM, WB empty-out)
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_src1  in  REG_AW  rs of instruction in ID
id_src2  in  REG_AW  rt of instruction in ID
id_uses_src2  in  1  ID instruction reads rt (R-type, beq/bne, sw)
id_branch  in  1  OR of the decode stage's five bra bits
id_jump  in  1  decode stage jmp_wire
pc_source  in  1  branch-taken from ID register compare
id_clock_off  in  1  decode stage clock_off (halt instruction in ID)
ex_reg_write  in  1  EX instruction writes a register
ex_mem_r  in  1  EX instruction is a load
ex_dest  in  REG_AW  EX final destination (after reg_dst mux)
mem_mem_r  in  1  MEM instruction is a load
mem_dest  in  REG_AW  MEM destination
pc_write  out  1  PC load enable
ifid_write  out  1  IF-ID register load enable
ifid_flush  out  1  zero the IF-ID register next edge
idex_bubble  out  1  load ID-EX with all-zero controls
halted  out  1  pipeline parked
stall_cnt  out  CNT_W  stall cycles since reset, saturating
flush_cnt  out  CNT_W  flushes since reset, saturating

Behaviour:
- One clock domain (clock). reset_n is asynchronous and active-low.
- Reset values: state=RUN, stall_cnt=0, flush_cnt=0, halted=0, drain counter=0.
- While reset_n is low, combinational outputs are forced to pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
- Register x0 never matches: any comparison where the dest is 0 is false.
- Hazard terms, evaluated combinationally in the same cycle:
  - m1 = (dest==id_src1) | (id_uses_src2 & dest==id_src2), with dest nonzero.
  - lu = ex_mem_r & m1(ex_dest). Load-use.
  - bx = id_branch & ex_reg_write & m1(ex_dest). Branch needs an EX result; covers EX loads.
  - bm = id_branch & mem_mem_r & m1(mem_dest). Branch needs load data still in MEM.
  - stall = lu | bx | bm.
  - A branch on an EX load therefore stalls 2 consecutive cycles: bx, then bm.
- FSM states: RUN, DRAIN, HALT.
- RUN:
  - If stall: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. Branch resolution and halt are ignored this cycle.
  - Else if id_clock_off: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=0 (the halt instruction proceeds). Next state DRAIN, drain counter=0.
  - Else if (id_branch & pc_source) | id_jump: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0; flush_cnt increments.
  - Else all enables 1, ifid_flush=0, idex_bubble=0.
- DRAIN:
  - pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. All hazard and branch inputs are ignored.
  - Drain counter increments each cycle. At DRAIN_CYCLES-1 the next state is HALT.
- HALT:
  - Same outputs as DRAIN, with halted=1 (registered, asserted the first cycle in HALT).
  - Sticky until reset.
- Counter rules:
  - stall_cnt increments once per RUN cycle with stall=1.
  - flush_cnt increments once per RUN branch/jump flush; halt flushes are not counted.
  - Both hold at all-ones (no wrap) and do not change in DRAIN or HALT.
- Simultaneous events:
  - stall overrides taken branch, jump and halt; the branch re-resolves after the stall.
  - id_clock_off overrides jump or branch in the same cycle.
- reset_n asserted mid-DRAIN or in HALT returns to RUN and clears the counters asynchronously.

Test Plan:
- Load-use: ex_mem_r=1, ex_dest=5, id_src1=5 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt 0->1; next cycle (EX no longer a load) enables return to 1.
- x0 guard: ex_mem_r=1, ex_dest=0, id_src1=0 -> no stall, pc_write=1, stall_cnt stays 0.
- Branch on load: id_branch=1, id_src2=7, id_uses_src2=1, ex_mem_r=1, ex_reg_write=1, ex_dest=7; next cycle mem_mem_r=1, mem_dest=7 -> exactly 2 stall cycles; third cycle with pc_source=1 gives ifid_flush=1; stall_cnt=2, flush_cnt=1.
- Jump while stalled: id_jump=1 with lu true -> ifid_flush=0 that cycle; next cycle (no hazard) ifid_flush=1.
- Halt: id_clock_off=1 in RUN -> ifid_flush=1 that cycle, then 3 DRAIN cycles with idex_bubble=1, halted=1 on the 4th cycle and held; branch inputs toggling in HALT cause no change; reset_n low -> halted=0, pc_write=0 immediately.
- Saturation: force 2^16+3 stall cycles -> stall_cnt=16'hFFFF.
